// File: rtl/attn_bank_ring.sv
// Ring of BANK_NUM frame banks between the spike-accumulation writer and the attention reader.
// The writer fills the tail bank and commits it; the reader randomly addresses the head bank and releases it.
module attn_bank_ring_ram #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4096,
    parameter int AW     = 12
) (
    input  logic              s_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    // No reset on the array or read port so the RAM maps onto block memory.
    always_ff @(posedge s_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;
endmodule

module attn_bank_ring #(
    parameter int DATA_W    = 20,
    parameter int FRAME_LEN = 4096,
    parameter int BANK_NUM  = 2,
    parameter int RD_LAT    = 1,
    localparam int AW       = $clog2(FRAME_LEN),
    localparam int BW       = $clog2(BANK_NUM)
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_flush,
    output logic              o_wr_ready,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_done,
    output logic [AW:0]       o_rd_len,
    output logic              o_empty,
    output logic [BW:0]       o_banks_used,
    output logic              o_overflow
);
    logic [BW-1:0]                      r_wr_ptr, r_rd_ptr, r_rd_bank;
    logic [AW-1:0]                      r_wr_addr;
    logic [BW:0]                        r_banks_used;
    logic [BANK_NUM-1:0][AW:0]          r_len;
    logic                               r_overflow, r_rd_seen, r_rd_oob;
    logic [RD_LAT:1]                    r_vld_pipe;
    logic [BANK_NUM-1:0][DATA_W-1:0]    w_q;
    logic                               w_wr_acc, w_last, w_flush_go, w_commit, w_rel, w_rd_go, w_oob;
    logic [AW:0]                        w_commit_len;
    logic [DATA_W-1:0]                  w_rd_word;

    assign o_wr_ready   = (r_banks_used != (BW+1)'(BANK_NUM));
    assign o_empty      = (r_banks_used == '0);
    assign o_banks_used = r_banks_used;
    assign o_overflow   = r_overflow;
    assign o_rd_len     = o_empty ? '0 : r_len[r_rd_ptr];
    assign o_rd_valid   = r_vld_pipe[RD_LAT];

    assign w_wr_acc     = i_wr_valid && o_wr_ready;
    assign w_last       = w_wr_acc && (r_wr_addr == AW'(FRAME_LEN - 1));
    // A flush needs at least one word in the frame; when it coincides with the last write it is the same commit.
    assign w_flush_go   = i_wr_flush && ((r_wr_addr != '0) || w_wr_acc);
    assign w_commit     = w_last || w_flush_go;
    assign w_commit_len = w_last ? (AW+1)'(FRAME_LEN) : ({1'b0, r_wr_addr} + (AW+1)'(w_wr_acc));
    assign w_rel        = i_rd_done && !o_empty;
    assign w_rd_go      = i_rd_en && !o_empty;
    assign w_oob        = ({1'b0, i_rd_addr} >= o_rd_len);

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_wr_addr    <= '0;
            r_banks_used <= '0;
            r_len        <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (i_wr_valid && !o_wr_ready) r_overflow <= 1'b1;
            if (w_commit) begin
                r_len[r_wr_ptr] <= w_commit_len;
                r_wr_ptr        <= r_wr_ptr + BW'(1);
                r_wr_addr       <= '0;
            end else if (w_wr_acc) begin
                r_wr_addr <= r_wr_addr + AW'(1);
            end
            if (w_rel) r_rd_ptr <= r_rd_ptr + BW'(1);
            unique case ({w_commit, w_rel})
                2'b10:   r_banks_used <= r_banks_used + (BW+1)'(1);
                2'b01:   r_banks_used <= r_banks_used - (BW+1)'(1);
                default: r_banks_used <= r_banks_used;
            endcase
        end
    end

    // Bank and range check are latched with the request, so a same-cycle release cannot redirect the read.
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_vld_pipe <= '0;
            r_rd_bank  <= '0;
            r_rd_oob   <= 1'b0;
            r_rd_seen  <= 1'b0;
        end else begin
            r_vld_pipe[1] <= w_rd_go;
            for (int k = 2; k <= RD_LAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
            if (w_rd_go) begin
                r_rd_bank <= r_rd_ptr;
                r_rd_oob  <= w_oob;
                r_rd_seen <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        attn_bank_ring_ram #(.DATA_W(DATA_W), .DEPTH(FRAME_LEN), .AW(AW)) u_ram (
            .s_clk   (s_clk),
            .i_we    (w_wr_acc && (r_wr_ptr == BW'(b))),
            .i_waddr (r_wr_addr),
            .i_wdata (i_wr_data),
            .i_re    (w_rd_go && (r_rd_ptr == BW'(b))),
            .i_raddr (i_rd_addr),
            .o_rdata (w_q[b])
        );
    end

    // RAM outputs only change on a read, so this mux holds the last word between reads.
    assign w_rd_word = (!r_rd_seen || r_rd_oob) ? '0 : w_q[r_rd_bank];

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] r_dout;
        always_ff @(posedge s_clk or negedge s_rst_n) begin
            if (!s_rst_n)           r_dout <= '0;
            else if (r_vld_pipe[1]) r_dout <= w_rd_word;
        end
        assign o_rd_data = r_dout;
    end else begin : g_lat1
        assign o_rd_data = w_rd_word;
    end
endmodule

// File: tb/tb_attn_bank_ring.sv
// Directed bench: dut a is 2 banks x 16 words, latency 1; dut b is 4 banks x 8 words, latency 2.
module tb_attn_bank_ring;
    logic s_clk = 1'b0;
    logic s_rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 s_clk = ~s_clk;

    logic        a_wr_valid = 0, a_wr_flush = 0, a_rd_en = 0, a_rd_done = 0;
    logic [19:0] a_wr_data = 0, a_rd_data;
    logic [3:0]  a_rd_addr = 0;
    logic        a_wr_ready, a_rd_valid, a_empty, a_overflow;
    logic [4:0]  a_rd_len;
    logic [1:0]  a_banks_used;

    logic        b_wr_valid = 0, b_wr_flush = 0, b_rd_en = 0, b_rd_done = 0;
    logic [19:0] b_wr_data = 0, b_rd_data;
    logic [2:0]  b_rd_addr = 0;
    logic        b_wr_ready, b_rd_valid, b_empty, b_overflow;
    logic [3:0]  b_rd_len;
    logic [2:0]  b_banks_used;

    attn_bank_ring #(.DATA_W(20), .FRAME_LEN(16), .BANK_NUM(2), .RD_LAT(1)) dut_a (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .i_wr_valid(a_wr_valid), .i_wr_data(a_wr_data),
        .i_wr_flush(a_wr_flush), .o_wr_ready(a_wr_ready), .i_rd_en(a_rd_en), .i_rd_addr(a_rd_addr),
        .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .i_rd_done(a_rd_done), .o_rd_len(a_rd_len),
        .o_empty(a_empty), .o_banks_used(a_banks_used), .o_overflow(a_overflow));

    attn_bank_ring #(.DATA_W(20), .FRAME_LEN(8), .BANK_NUM(4), .RD_LAT(2)) dut_b (
        .s_clk(s_clk), .s_rst_n(s_rst_n), .i_wr_valid(b_wr_valid), .i_wr_data(b_wr_data),
        .i_wr_flush(b_wr_flush), .o_wr_ready(b_wr_ready), .i_rd_en(b_rd_en), .i_rd_addr(b_rd_addr),
        .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .i_rd_done(b_rd_done), .o_rd_len(b_rd_len),
        .o_empty(b_empty), .o_banks_used(b_banks_used), .o_overflow(b_overflow));

    // Stimulus helpers: entered at a negedge, return at the next negedge with strobes dropped.
    task automatic a_wr(input int v);
        a_wr_valid = 1; a_wr_data = 20'(v); @(negedge s_clk); a_wr_valid = 0;
    endtask
    task automatic a_rd(input int addr);
        a_rd_en = 1; a_rd_addr = 4'(addr); @(negedge s_clk); a_rd_en = 0;
    endtask
    task automatic a_done();
        a_rd_done = 1; @(negedge s_clk); a_rd_done = 0;
    endtask
    task automatic b_wr(input int v);
        b_wr_valid = 1; b_wr_data = 20'(v); @(negedge s_clk); b_wr_valid = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge s_clk);
        n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b exp 1", a_empty); end
        n_cmp++; if (a_wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b exp 1", a_wr_ready); end
        n_cmp++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", a_rd_valid); end
        n_cmp++; if (a_rd_data !== 20'd0) begin n_err++; $display("FAIL rst_data: got %0d exp 0", a_rd_data); end
        n_cmp++; if (a_overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b exp 0", a_overflow); end
        n_cmp++; if (a_rd_len !== 5'd0) begin n_err++; $display("FAIL rst_len: got %0d exp 0", a_rd_len); end
        n_cmp++; if (a_banks_used !== 2'd0) begin n_err++; $display("FAIL rst_used: got %0d exp 0", a_banks_used); end
        s_rst_n = 1;
        @(negedge s_clk);
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < 16; i++) a_wr(i);
        n_cmp++; if (a_banks_used !== 2'd1) begin n_err++; $display("FAIL ff_used: got %0d exp 1", a_banks_used); end
        n_cmp++; if (a_rd_len !== 5'd16) begin n_err++; $display("FAIL ff_len: got %0d exp 16", a_rd_len); end
        a_rd(3);
        n_cmp++; if (a_rd_valid !== 1'b1) begin n_err++; $display("FAIL ff_v3: got %b exp 1", a_rd_valid); end
        n_cmp++; if (a_rd_data !== 20'd3) begin n_err++; $display("FAIL ff_d3: got %0d exp 3", a_rd_data); end
        a_rd(15);
        n_cmp++; if (a_rd_data !== 20'd15) begin n_err++; $display("FAIL ff_d15: got %0d exp 15", a_rd_data); end
        @(negedge s_clk);
        n_cmp++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL ff_vdrop: got %b exp 0", a_rd_valid); end
        n_cmp++; if (a_rd_data !== 20'd15) begin n_err++; $display("FAIL ff_hold: got %0d exp 15", a_rd_data); end
        a_done();
        n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL ff_empty: got %b exp 1", a_empty); end
        n_cmp++; if (a_rd_len !== 5'd0) begin n_err++; $display("FAIL ff_len0: got %0d exp 0", a_rd_len); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) a_wr(100 + i);
        a_wr_flush = 1; a_wr(105); a_wr_flush = 0;
        n_cmp++; if (a_rd_len !== 5'd6) begin n_err++; $display("FAIL fl_len: got %0d exp 6", a_rd_len); end
        n_cmp++; if (a_banks_used !== 2'd1) begin n_err++; $display("FAIL fl_used: got %0d exp 1", a_banks_used); end
        a_rd(5);
        n_cmp++; if (a_rd_data !== 20'd105) begin n_err++; $display("FAIL fl_d5: got %0d exp 105", a_rd_data); end
        a_rd(7);
        n_cmp++; if (a_rd_valid !== 1'b1) begin n_err++; $display("FAIL fl_oob_v: got %b exp 1", a_rd_valid); end
        n_cmp++; if (a_rd_data !== 20'd0) begin n_err++; $display("FAIL fl_oob_d: got %0d exp 0", a_rd_data); end
        a_rd(0);
        n_cmp++; if (a_rd_data !== 20'd100) begin n_err++; $display("FAIL fl_d0: got %0d exp 100", a_rd_data); end
        a_wr_flush = 1; @(negedge s_clk); a_wr_flush = 0;
        n_cmp++; if (a_banks_used !== 2'd1) begin n_err++; $display("FAIL fl_empty_flush: got %0d exp 1", a_banks_used); end
        a_done();
        a_done();
        n_cmp++; if (a_banks_used !== 2'd0) begin n_err++; $display("FAIL fl_done_empty: got %0d exp 0", a_banks_used); end
        a_rd(1);
        n_cmp++; if (a_rd_valid !== 1'b0) begin n_err++; $display("FAIL fl_rd_empty_v: got %b exp 0", a_rd_valid); end
        n_cmp++; if (a_rd_data !== 20'd100) begin n_err++; $display("FAIL fl_rd_empty_hold: got %0d exp 100", a_rd_data); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) a_wr(200 + i);
        for (int i = 0; i < 15; i++) a_wr(300 + i);
        a_rd_done = 1; a_rd_en = 1; a_rd_addr = 4'd2;
        a_wr(315);
        a_rd_done = 0; a_rd_en = 0;
        n_cmp++; if (a_banks_used !== 2'd1) begin n_err++; $display("FAIL sim_used: got %0d exp 1", a_banks_used); end
        n_cmp++; if (a_rd_valid !== 1'b1) begin n_err++; $display("FAIL sim_v: got %b exp 1", a_rd_valid); end
        n_cmp++; if (a_rd_data !== 20'd202) begin n_err++; $display("FAIL sim_old: got %0d exp 202", a_rd_data); end
        a_rd(2);
        n_cmp++; if (a_rd_data !== 20'd302) begin n_err++; $display("FAIL sim_new: got %0d exp 302", a_rd_data); end
        a_done();
        n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL sim_empty: got %b exp 1", a_empty); end
    endtask

    task automatic test_ring_overflow();
        for (int i = 0; i < 32; i++) b_wr(i);
        n_cmp++; if (b_banks_used !== 3'd4) begin n_err++; $display("FAIL rg_used: got %0d exp 4", b_banks_used); end
        n_cmp++; if (b_wr_ready !== 1'b0) begin n_err++; $display("FAIL rg_ready: got %b exp 0", b_wr_ready); end
        n_cmp++; if (b_overflow !== 1'b0) begin n_err++; $display("FAIL rg_ovf0: got %b exp 0", b_overflow); end
        b_wr(99);
        n_cmp++; if (b_overflow !== 1'b1) begin n_err++; $display("FAIL rg_ovf1: got %b exp 1", b_overflow); end
        n_cmp++; if (b_banks_used !== 3'd4) begin n_err++; $display("FAIL rg_used_ovf: got %0d exp 4", b_banks_used); end
        for (int f = 0; f < 4; f++) begin
            n_cmp++; if (b_rd_len !== 4'd8) begin n_err++; $display("FAIL rg_len f%0d: got %0d exp 8", f, b_rd_len); end
            for (int c = 0; c < 10; c++) begin
                if (c == 1) begin
                    n_cmp++; if (b_rd_valid !== 1'b0) begin n_err++; $display("FAIL rg_lat f%0d: got %b exp 0", f, b_rd_valid); end
                end
                if (c >= 2) begin
                    n_cmp++; if (b_rd_valid !== 1'b1) begin n_err++; $display("FAIL rg_v f%0d c%0d: got %b exp 1", f, c, b_rd_valid); end
                    n_cmp++; if (b_rd_data !== 20'(f*8 + c - 2)) begin n_err++; $display("FAIL rg_d f%0d: got %0d exp %0d", f, b_rd_data, f*8 + c - 2); end
                end
                b_rd_en = (c < 8); b_rd_addr = 3'(c);
                @(negedge s_clk);
            end
            n_cmp++; if (b_rd_valid !== 1'b0) begin n_err++; $display("FAIL rg_vend f%0d: got %b exp 0", f, b_rd_valid); end
            b_rd_done = 1; @(negedge s_clk); b_rd_done = 0;
        end
        n_cmp++; if (b_empty !== 1'b1) begin n_err++; $display("FAIL rg_empty: got %b exp 1", b_empty); end
        n_cmp++; if (b_overflow !== 1'b1) begin n_err++; $display("FAIL rg_sticky: got %b exp 1", b_overflow); end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 19; i++) a_wr(400 + i);
        a_rd(1);
        n_cmp++; if (a_rd_data !== 20'd401) begin n_err++; $display("FAIL rm_pre: got %0d exp 401", a_rd_data); end
        #2 s_rst_n = 0;
        #1;
        n_cmp++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL rm_empty: got %b exp 1", a_empty); end
        n_cmp++; if (a_banks_used !== 2'd0) begin n_err++; $display("FAIL rm_used: got %0d exp 0", a_banks_used); end
        n_cmp++; if (a_rd_len !== 5'd0) begin n_err++; $display("FAIL rm_len: got %0d exp 0", a_rd_len); end
        n_cmp++; if (a_rd_data !== 20'd0) begin n_err++; $display("FAIL rm_data: got %0d exp 0", a_rd_data); end
        n_cmp++; if (b_overflow !== 1'b0) begin n_err++; $display("FAIL rm_ovf: got %b exp 0", b_overflow); end
        @(negedge s_clk); s_rst_n = 1; @(negedge s_clk);
        for (int i = 0; i < 16; i++) a_wr(500 + i);
        n_cmp++; if (a_rd_len !== 5'd16) begin n_err++; $display("FAIL rm_len16: got %0d exp 16", a_rd_len); end
        n_cmp++; if (a_banks_used !== 2'd1) begin n_err++; $display("FAIL rm_used1: got %0d exp 1", a_banks_used); end
        a_rd(0);
        n_cmp++; if (a_rd_data !== 20'd500) begin n_err++; $display("FAIL rm_d0: got %0d exp 500", a_rd_data); end
        a_rd(9);
        n_cmp++; if (a_rd_data !== 20'd509) begin n_err++; $display("FAIL rm_d9: got %0d exp 509", a_rd_data); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_simultaneous();
        test_ring_overflow();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/attn_bank_ring.md
Name: attn_bank_ring

Overview:
Parametrised N-bank frame buffer that stores (Q*K^T) spike-accumulation results between the SpikesAccumulation producer and the attention consumer. The writer fills one bank per frame, and each completed frame is committed to a ring. The reader randomly addresses the oldest committed frame and releases it when done. This generalises the fixed two-bank ping-pong store with configurable width, depth and bank count, registered read-valid, partial-frame flush with length reporting, occupancy output and overflow detection.

Parameters:
DATA_W, 20, bits per word ($clog2(2*SYSTOLIC_UNIT_NUM)*TIME_STEPS in the current build)
FRAME_LEN, 4096, words per full frame (FINAL_FMAPS_WIDTH^2); any value >= 2
BANK_NUM, 2, bank count; power of two, >= 2
RD_LAT, 1, read latency in cycles, 1 or 2 (2 adds an output register)
AW (localparam), $clog2(FRAME_LEN), address width
BW (localparam), $clog2(BANK_NUM), bank pointer width

Ports:
s_clk  in  1  clock
s_rst_n  in  1  asynchronous active-low reset
i_wr_valid  in  1  write strobe
i_wr_data  in  DATA_W  write word
i_wr_flush  in  1  commit current partial frame
o_wr_ready  out  1  a bank is free (~full)
i_rd_en  in  1  read request on head bank
i_rd_addr  in  AW  read word address within head bank
o_rd_data  out  DATA_W  read word
o_rd_valid  out  1  o_rd_data valid, RD_LAT cycles after i_rd_en
i_rd_done  in  1  release head bank
o_rd_len  out  AW+1  committed word count of head bank
o_empty  out  1  no committed bank
o_banks_used  out  BW+1  committed bank count
o_overflow  out  1  sticky: write attempted while not ready

Behaviour:
- Reset (async assert, sync release): wr_ptr, rd_ptr, wr_addr = 0; banks_used = 0. Outputs: o_rd_valid = 0, o_rd_data = 0, o_overflow = 0, o_empty = 1, o_wr_ready = 1, o_rd_len = 0. RAM contents are not cleared. Reset mid-frame discards the partial frame and all committed frames.
- Write acceptance: a write is accepted when i_wr_valid && o_wr_ready. The word goes to bank[wr_ptr][wr_addr], and wr_addr increments.
- Write with ready = 0: dropped, and o_overflow is set (sticky until reset).
- Full-frame commit: an accepted write at wr_addr == FRAME_LEN-1 commits the bank.
  - Length is stored as FRAME_LEN.
  - wr_ptr advances modulo BANK_NUM; wr_addr returns to 0.
- Flush: i_wr_flush commits with length wr_addr, plus 1 if a write is accepted in the same cycle.
  - Flush with zero words pending (wr_addr == 0, no accepted write) is ignored.
  - Flush together with a last-address write produces exactly one commit.
- Per-bank length registers are AW+1 bits. o_rd_len = len[rd_ptr], or 0 when empty.
- Occupancy: o_wr_ready = (banks_used != BANK_NUM); o_empty = (banks_used == 0).
- Simultaneous commit and release: banks_used unchanged, both pointers advance.
- Release: i_rd_done while empty is ignored. Otherwise rd_ptr advances modulo BANK_NUM and banks_used decrements.
- Read: i_rd_en is ignored while empty, so o_rd_valid stays 0.
  - Otherwise o_rd_valid = 1 exactly RD_LAT cycles later.
  - The bank select is captured at request time, so data comes from the bank that was head when i_rd_en was sampled, even if i_rd_done arrives in the same or a later cycle.
  - i_rd_addr >= o_rd_len returns 0 with valid still asserted.
  - o_rd_data holds its last value when not valid.
- Write and read of the same physical bank cannot occur: the head bank is never the write bank unless full, and no writes are accepted when full.
- Memory: one inferred simple dual-port RAM per bank (FRAME_LEN x DATA_W, synchronous read), mapped to BRAM.

Test Plan:
- BANK_NUM=2, FRAME_LEN=16: write 16 words 0..15 -> o_banks_used=1, o_rd_len=16. Reads of addr 3 and 15 return 3 and 15 with o_rd_valid exactly 1 cycle after i_rd_en.
- BANK_NUM=4, FRAME_LEN=8: write 4 frames (value = frame*8+addr), then hold i_wr_valid -> o_wr_ready=0, o_overflow=1. Readback over 4 releases returns 0..31 in order; o_empty=1 at end.
- Flush: write 5 words, pulse i_wr_flush with a 6th accepted write -> o_rd_len=6. Read addr 7 -> 0 with valid. Flush with nothing pending -> o_banks_used unchanged.
- Simultaneous: with banks_used=1, commit a frame and assert i_rd_done in the same cycle -> banks_used stays 1, head advances to the new frame. Read issued in the done cycle returns old-bank data.
- RD_LAT=2: read addr 4 -> valid 2 cycles later with correct data. Back-to-back reads on consecutive cycles give back-to-back valids.
- Reset mid-frame after 1 full + 3 partial words: assert s_rst_n=0 asynchronously -> outputs take reset values immediately. After release, a new 16-word frame reads back correctly from bank 0.
